// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for the immediate-extend stage: upstream instruction
// port and downstream extended-immediate port.
interface imm_extend_stage_if #(
  parameter int INSTR_W = 8,
  parameter int DATA_W  = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [DATA_W-1:0]  out_imm;
  logic               out_imm_neg;
  logic               out_has_imm;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_imm_neg, out_has_imm
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_imm_neg, out_has_imm
  );
endinterface

// File: rtl/imm_extend_stage.sv
// Decode-stage immediate generator: extends the instruction's immediate field
// per opcode and hands it downstream through a 2-entry skid buffer.
//
// state | meaning
// EMPTY | no entry buffered, out_valid low
// ONE   | head entry valid, tail free
// FULL  | head and tail valid, in_ready low
module imm_extend_stage #(
  parameter int INSTR_W = 8,
  parameter int FIELD_W = 3,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  imm_extend_stage_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  imm;
    logic               neg;
    logic               has_imm;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t new_entry;
  logic   in_ready, out_valid, push, pop;

  // Selector-1 on op 11 fills every bit above the field with ones,
  // independent of the field's own MSB.
  function automatic entry_t extend(input logic [INSTR_W-1:0] instr);
    entry_t           e;
    logic [1:0]       op;
    logic             fill;
    e       = '0;
    e.instr = instr;
    op      = instr[INSTR_W-1 -: 2];
    fill    = (op == 2'b11) && instr[INSTR_W-3];
    if (op != 2'b10) begin
      e.has_imm              = 1'b1;
      e.neg                  = fill;
      e.imm                  = {DATA_W{fill}};
      e.imm[FIELD_W-1:0]     = instr[FIELD_W-1:0];
    end
    return e;
  endfunction

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    new_entry = extend(bus.in_instr);
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_instr   = head_q.instr;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_imm_neg = head_q.neg;
  assign bus.out_has_imm = head_q.has_imm;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage: an 8-bit-immediate instance and a
// 16-bit-immediate instance sharing clock, reset and flush.
module tb_imm_extend_stage;
  logic clk;
  logic rst_n;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  imm_extend_stage_if #(.INSTR_W(8), .DATA_W(8))  bus_a ();
  imm_extend_stage_if #(.INSTR_W(8), .DATA_W(16)) bus_b ();

  imm_extend_stage #(.INSTR_W(8), .FIELD_W(3), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a)
  );

  imm_extend_stage #(.INSTR_W(8), .FIELD_W(3), .DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] instr);
    bus_a.in_valid = v;
    bus_a.in_instr = instr;
  endtask

  initial begin
    rst_n           = 1'b0;
    flush           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_instr  = 8'h00;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_instr  = 8'h00;
    bus_b.out_ready = 1'b1;
    #3;
    check("rst_valid", 32'(bus_a.out_valid), 32'h0);
    check("rst_instr", 32'(bus_a.out_instr), 32'h0);
    check("rst_imm",   32'(bus_a.out_imm),   32'h0);
    check("rst_imm_b", 32'(bus_b.out_imm),   32'h0);
    #9 rst_n = 1'b1;
    step();
    check("rel_ready", 32'(bus_a.in_ready), 32'h1);

    // Zero-extend / suppress / sign rules, one instruction per cycle.
    drive_a(1'b1, 8'h45);
    step();
    check("z_valid", 32'(bus_a.out_valid),   32'h1);
    check("z_instr", 32'(bus_a.out_instr),   32'h45);
    check("z_imm",   32'(bus_a.out_imm),     32'h05);
    check("z_neg",   32'(bus_a.out_imm_neg), 32'h0);
    check("z_has",   32'(bus_a.out_has_imm), 32'h1);
    drive_a(1'b1, 8'h87);
    step();
    check("op10_imm", 32'(bus_a.out_imm),     32'h00);
    check("op10_has", 32'(bus_a.out_has_imm), 32'h0);
    check("op10_val", 32'(bus_a.out_valid),   32'h1);
    drive_a(1'b1, 8'hE6);
    step();
    check("sx_imm", 32'(bus_a.out_imm),     32'hFE);
    check("sx_neg", 32'(bus_a.out_imm_neg), 32'h1);
    drive_a(1'b1, 8'hC6);
    step();
    check("zx11_imm", 32'(bus_a.out_imm),     32'h06);
    check("zx11_neg", 32'(bus_a.out_imm_neg), 32'h0);
    check("zx11_has", 32'(bus_a.out_has_imm), 32'h1);
    bus_a.in_valid = 1'b0;
    bus_a.in_instr = 'x;
    step();
    check("drain_valid", 32'(bus_a.out_valid), 32'h0);

    // Backpressure: third offer is held until the buffer drains.
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 8'h41);
    step();
    check("bp1_ready", 32'(bus_a.in_ready),  32'h1);
    check("bp1_instr", 32'(bus_a.out_instr), 32'h41);
    drive_a(1'b1, 8'h42);
    step();
    check("bp2_ready", 32'(bus_a.in_ready),  32'h0);
    check("bp2_instr", 32'(bus_a.out_instr), 32'h41);
    drive_a(1'b1, 8'h43);
    step();
    check("bp3_ready", 32'(bus_a.in_ready),  32'h0);
    check("bp3_hold",  32'(bus_a.out_instr), 32'h41);
    check("bp3_imm",   32'(bus_a.out_imm),   32'h01);
    bus_a.out_ready = 1'b1;
    step();
    check("bp_out42",  32'(bus_a.out_instr), 32'h42);
    check("bp_imm42",  32'(bus_a.out_imm),   32'h02);
    check("bp_ready1", 32'(bus_a.in_ready),  32'h1);
    step();
    check("bp_out43",  32'(bus_a.out_instr), 32'h43);
    check("bp_imm43",  32'(bus_a.out_imm),   32'h03);
    drive_a(1'b0, 8'h00);
    step();
    check("bp_empty", 32'(bus_a.out_valid), 32'h0);

    // Flush while FULL with a concurrent offer.
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 8'h41);
    step();
    drive_a(1'b1, 8'h42);
    step();
    check("fl_full", 32'(bus_a.in_ready), 32'h0);
    drive_a(1'b1, 8'h44);
    flush = 1'b1;
    step();
    check("fl_valid", 32'(bus_a.out_valid), 32'h0);
    check("fl_ready", 32'(bus_a.in_ready),  32'h1);
    flush           = 1'b0;
    drive_a(1'b0, 8'h00);
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_no44", 32'(bus_a.out_valid), 32'h0);
    end

    // Asynchronous reset between edges while FULL.
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 8'hE5);
    step();
    drive_a(1'b1, 8'h42);
    step();
    drive_a(1'b0, 8'h00);
    check("ar_full", 32'(bus_a.in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus_a.out_valid),   32'h0);
    check("ar_instr", 32'(bus_a.out_instr),   32'h0);
    check("ar_imm",   32'(bus_a.out_imm),     32'h0);
    check("ar_neg",   32'(bus_a.out_imm_neg), 32'h0);
    check("ar_has",   32'(bus_a.out_has_imm), 32'h0);
    #2 rst_n = 1'b1;
    step();
    check("ar_rel_ready", 32'(bus_a.in_ready),  32'h1);
    check("ar_rel_valid", 32'(bus_a.out_valid), 32'h0);
    bus_a.out_ready = 1'b1;

    // Wide immediate instance.
    bus_b.in_valid = 1'b1;
    bus_b.in_instr = 8'hE1;
    step();
    check("w_imm_sx", 32'(bus_b.out_imm),     32'hFFF9);
    check("w_neg_sx", 32'(bus_b.out_imm_neg), 32'h1);
    bus_b.in_instr = 8'h21;
    step();
    check("w_imm_zx", 32'(bus_b.out_imm),     32'h0001);
    check("w_neg_zx", 32'(bus_b.out_imm_neg), 32'h0);
    check("w_has_zx", 32'(bus_b.out_has_imm), 32'h1);
    bus_b.in_valid = 1'b0;
    step();
    check("w_empty", 32'(bus_b.out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
